fifo_occ_ctrl: RTL

- Synchronous single-clock FIFO for the compression datapath: storage, pointer control, occupancy count, threshold flags and sticky error flags.
- Parametrised in data width, depth and thresholds.
- Sits between the Stage1 compressor front end and downstream packing logic.
- Replaces bare pointer-only FIFO controllers in new designs.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_occ_ctrl_if.sv | 37 +++
 rtl/fifo_regfile.sv | 36 +++
 rtl/fifo_occ_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the compression-datapath FIFO slice.
// Contents:
//   fifo_depth()    - entry count for a given pointer width, never below 1
//   DEF_DATA_WIDTH  - default word width
//   DEF_ADDR_WIDTH  - default pointer width
//   fifo_status_t   - packed flag bundle used by the controller and monitors
// Optional feature macro used by fifo_occ_ctrl: FIFO_FWFT_EN.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  // Depth from pointer width; a degenerate width still yields one entry.
  function automatic int fifo_depth(input int addr_width);
    if (addr_width < 1) begin
      return 1;
    end else begin
      return int'(32'd1 << addr_width);
    end
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_occ_ctrl_if.sv
// Handshake/status bundle between a FIFO producer/consumer and fifo_occ_ctrl.
// Signals:
//   wr, wr_data, rd, err_clr       - driven by master
//   rd_data, count, full, empty,
//   almost_full, almost_empty,
//   overflow, underflow            - driven by slave (the FIFO)
interface fifo_occ_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, wr_data, rd, err_clr,
    input  rd_data, count, full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr, wr_data, rd, err_clr,
    output rd_data, count, full, empty, almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_WIDTH storage for fifo_occ_ctrl. Contents are not reset.
// Ports:
//   clk    in  clock, rising edge
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out combinational read data at raddr
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_occ_ctrl.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky errors.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    fifo_occ_ctrl_if.slave: wr/wr_data/rd/err_clr in,
//          rd_data/count/full/empty/almost_full/almost_empty/overflow/underflow out
// Optional feature: define FIFO_FWFT_EN for first-word fall-through, where
// rd_data shows the head word combinationally and rd acts as a pop.
module fifo_occ_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic            clk,
  input  logic            reset,
  fifo_occ_ctrl_if.slave  bus
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [CW-1:0]         count_r;
  fifo_status_t          status_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [CW-1:0]         count_next_s;
  fifo_status_t          status_next_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Acceptance from pre-edge state; a full FIFO takes a write if a read frees a slot.
  assign wr_acc_s = bus.wr & (~status_r.full | bus.rd);
  assign rd_acc_s = bus.rd & ~status_r.empty;

  // Next occupancy and the flags it implies, so flags register alongside count.
  always_comb begin
    count_next_s  = count_r;
    status_next_s = status_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
    status_next_s.full         = (count_next_s == CW'(DEPTH));
    status_next_s.empty        = (count_next_s == CW'(0));
    status_next_s.almost_full  = (count_next_s >= CW'(AF_THRESH));
    status_next_s.almost_empty = (count_next_s <= CW'(AE_THRESH));
    // A new error in the same cycle as err_clr wins over the clear.
    if (bus.wr & status_r.full & ~bus.rd) begin
      status_next_s.overflow = 1'b1;
    end else if (bus.err_clr) begin
      status_next_s.overflow = 1'b0;
    end else begin
      status_next_s.overflow = status_r.overflow;
    end
    if (bus.rd & status_r.empty) begin
      status_next_s.underflow = 1'b1;
    end else if (bus.err_clr) begin
      status_next_s.underflow = 1'b0;
    end else begin
      status_next_s.underflow = status_r.underflow;
    end
  end

  // Pointer, count and flag state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r <= {ADDR_WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
      status_r <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                    almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
      end
      count_r  <= count_next_s;
      status_r <= status_next_s;
    end
  end

`ifdef FIFO_FWFT_EN
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Head word falls through; nothing valid to show while empty.
  always_comb begin
    if (status_r.empty) begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      rd_data_s = rdata_s;
    end
  end

  assign bus.rd_data = rd_data_s;
`else
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Registered read data, updated only on an accepted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_acc_s) begin
      rd_data_r <= rdata_s;
    end
  end

  assign bus.rd_data = rd_data_r;
`endif

  assign bus.count        = count_r;
  assign bus.full         = status_r.full;
  assign bus.empty        = status_r.empty;
  assign bus.almost_full  = status_r.almost_full;
  assign bus.almost_empty = status_r.almost_empty;
  assign bus.overflow     = status_r.overflow;
  assign bus.underflow    = status_r.underflow;

endmodule
